sram_access_arbiter: RTL
========================

Name: sram_access_arbiter

Overview:
- Parametrised N-channel arbiter that shares one single-port SRAM (active-low CSN/WRN interface) between several requesters, e.g. the coefficient-update path and the FIR memory-read path.
- Replaces state-based static muxing with per-access request/acknowledge handshaking.
- Adds selectable fixed-priority or round-robin arbitration, lock (burst) ownership, registered SRAM strobes and read-data return routed to the requesting channel.
- Sits between the FSM/top-level request sources and the SP-SRAM instance.

Parameters:
- NUM_CH, 3, number of requesting channels (1..8); channel 0 is the update/write source by convention.
- ADDR_W, 4, SRAM address width.
- DATA_W, 16, SRAM data width.
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- iClk12M  input  1  system clock, all state updates on rising edge.
- iRsn  input  1  asynchronous active-low reset.
- iReq  input  NUM_CH  per-channel access request.
- iWrn  input  NUM_CH  per-channel access type, 0 = write, 1 = read.
- iLock  input  NUM_CH  per-channel lock request, sampled with an accepted access.
- iAddr  input  NUM_CH*ADDR_W  flattened addresses; channel k occupies bits [k*ADDR_W +: ADDR_W].
- iWrDt  input  NUM_CH*DATA_W  flattened write data, same packing as iAddr.
- oAck  output  NUM_CH  combinational one-hot acknowledge; access accepted at an edge where iReq[k]&oAck[k].
- oCsn  output  1  SRAM chip select, active low.
- oWrn  output  1  SRAM write enable, active low.
- oAddr  output  ADDR_W  SRAM address.
- oWrDt  output  DATA_W  SRAM write data.
- iRdDt  input  DATA_W  SRAM read data, valid one cycle after read strobe.
- oRdDt  output  DATA_W  returned read data.
- oRdVld  output  NUM_CH  one-hot read-data valid for the owning channel.
- oLocked  output  1  high while the arbiter is in LOCKED state.

Behaviour:
- Reset (iRsn=0, asynchronous):
  - oCsn=1, oWrn=1, oAddr=0, oWrDt=0, oRdDt=0, oRdVld=0, oLocked=0.
  - State ARB, round-robin pointer=0, lock owner=0.
  - oAck forced to 0 while iRsn=0.
- Handshake:
  - At most one oAck bit high per cycle, and only for a channel with iReq high.
  - Accept at cycle t → cycle t+1: oCsn=0, oWrn=captured iWrn[k], oAddr/oWrDt=captured channel-k values.
  - Cycle with no accept → oCsn=1, oWrn=1; oAddr/oWrDt hold their last values.
  - Throughput one access per cycle; requests to the SRAM are issued strictly in acceptance order.
- Read return:
  - Read accepted at t → oRdVld[k]=1 at t+2 with oRdDt=iRdDt.
  - oRdDt holds its value when oRdVld=0.
  - Back-to-back reads yield back-to-back oRdVld pulses.
- Arbitration, state ARB:
  - ARB_MODE=0: lowest-index requesting channel acknowledged.
  - ARB_MODE=1: first requesting channel at or after the pointer (cyclic) acknowledged; after an accept from k, pointer = (k+1) mod NUM_CH.
  - Pointer unchanged when there is no accept.
- Lock FSM:
  - ARB→LOCKED on accept from k with iLock[k]=1; owner=k, oLocked=1.
  - LOCKED: only the owner can be acknowledged, and oAck[owner]=iReq[owner]; other channels are stalled.
  - LOCKED→ARB on an owner accept with iLock=0, i.e. that final access is still performed; round-robin pointer = owner+1.
  - LOCKED→ARB also when the owner has iReq=0 and iLock=0 in the same cycle.
  - Owner with iReq=0 and iLock=1 → remain LOCKED, no SRAM access.
- Boundaries:
  - NUM_CH=1: oAck=iReq while iRsn=1.
  - Pointer wraps from NUM_CH-1 to 0.
  - A pending read return completes even if the lock state changes.
  - Reset mid-access discards in-flight strobes and pending oRdVld immediately.
  - Write then read of the same address on consecutive cycles returns the newly written data; SRAM ordering is preserved.

Test Plan:
- Reset with iReq=3'b111 held → oAck=0, oCsn=1, oWrn=1 during reset; after release (ARB_MODE=1) oAck=001, then 010, then 100, then 001 on consecutive cycles.
- ARB_MODE=0, iReq=3'b110 held 4 cycles → oAck=010 every cycle; channel 2 never acknowledged.
- Ch0 writes 0xA5A5 to addr 3 at t (iWrn=0) → t+1: oCsn=0, oWrn=0, oAddr=3, oWrDt=0xA5A5.
- Ch2 reads addr 3 at t+1; bench SRAM model returns 0xA5A5 → oRdVld=100 and oRdDt=0xA5A5 at t+3.
- Ch1 issues a 4-access locked burst (iLock=1 on the first 3 accesses, 0 on the last) while ch0/ch2 request → oLocked=1 from the first accept until after the 4th; only oAck[1] during the burst; next grant goes to ch2 (pointer=2).
- Assert iRsn=0 in the cycle after a read accept → no oRdVld pulse; all outputs at reset values; arbitration resumes at pointer 0.

Source files
------------

// File: rtl/sram_access_arbiter.sv
// N-channel request/acknowledge arbiter in front of a single-port SRAM.
// Fixed-priority or round-robin grant, burst locking and routed read return.
module sram_access_arbiter #(
  parameter int NUM_CH   = 3,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int ARB_MODE = 1
) (
  input  logic                       iClk12M,
  input  logic                       iRsn,
  input  logic [NUM_CH-1:0]          iReq,
  input  logic [NUM_CH-1:0]          iWrn,
  input  logic [NUM_CH-1:0]          iLock,
  input  logic [NUM_CH*ADDR_W-1:0]   iAddr,
  input  logic [NUM_CH*DATA_W-1:0]   iWrDt,
  output logic [NUM_CH-1:0]          oAck,
  output logic                       oCsn,
  output logic                       oWrn,
  output logic [ADDR_W-1:0]          oAddr,
  output logic [DATA_W-1:0]          oWrDt,
  input  logic [DATA_W-1:0]          iRdDt,
  output logic [DATA_W-1:0]          oRdDt,
  output logic [NUM_CH-1:0]          oRdVld,
  output logic                       oLocked
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {
    S_ARB,
    S_LOCKED
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     gidx, nxt_idx;
  logic [CW:0]       sum, inc;
  logic [NUM_CH-1:0] gnt;
  logic              found, accept;

  logic              csn_q, csn_d;
  logic              wrn_q, wrn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wrdt_q, wrdt_d;
  logic [NUM_CH-1:0] rd_pend_q, rd_pend_d;
  logic [NUM_CH-1:0] rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] rddt_q, rddt_d;

  // Cyclic search starting at the pointer (or at 0 for fixed priority).
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    sum   = '0;
    if (state_q == S_LOCKED) begin
      gidx  = owner_q;
      found = iReq[owner_q];
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        sum = (CW+1)'(i);
        if (ARB_MODE != 0) sum = sum + {1'b0, ptr_q};
        if (sum >= (CW+1)'(NUM_CH)) sum = sum - (CW+1)'(NUM_CH);
        if (!found && iReq[sum[CW-1:0]]) begin
          found = 1'b1;
          gidx  = sum[CW-1:0];
        end
      end
    end
    gnt[gidx] = found;
  end

  assign accept  = found;
  assign inc     = {1'b0, gidx} + (CW+1)'(1);
  assign nxt_idx = (inc >= (CW+1)'(NUM_CH)) ? '0 : inc[CW-1:0];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    csn_d     = 1'b1;
    wrn_d     = 1'b1;
    addr_d    = addr_q;
    wrdt_d    = wrdt_q;
    rd_pend_d = '0;
    rd_vld_d  = rd_pend_q;
    rddt_d    = (|rd_vld_q) ? iRdDt : rddt_q;
    if (accept) begin
      csn_d  = 1'b0;
      wrn_d  = iWrn[gidx];
      addr_d = iAddr[gidx*ADDR_W +: ADDR_W];
      wrdt_d = iWrDt[gidx*DATA_W +: DATA_W];
      ptr_d  = nxt_idx;
      if (iWrn[gidx]) rd_pend_d = gnt;
    end
    // Dropping the lock releases ownership whether or not a last access rides along.
    unique case (state_q)
      S_ARB: begin
        if (accept && iLock[gidx]) begin
          state_d = S_LOCKED;
          owner_d = gidx;
        end
      end
      S_LOCKED: begin
        if (!iLock[owner_q]) state_d = S_ARB;
      end
      default: state_d = S_ARB;
    endcase
  end

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q   <= S_ARB;
      ptr_q     <= '0;
      owner_q   <= '0;
      csn_q     <= 1'b1;
      wrn_q     <= 1'b1;
      addr_q    <= '0;
      wrdt_q    <= '0;
      rd_pend_q <= '0;
      rd_vld_q  <= '0;
      rddt_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      csn_q     <= csn_d;
      wrn_q     <= wrn_d;
      addr_q    <= addr_d;
      wrdt_q    <= wrdt_d;
      rd_pend_q <= rd_pend_d;
      rd_vld_q  <= rd_vld_d;
      rddt_q    <= rddt_d;
    end
  end

  assign oAck    = iRsn ? gnt : '0;
  assign oCsn    = csn_q;
  assign oWrn    = wrn_q;
  assign oAddr   = addr_q;
  assign oWrDt   = wrdt_q;
  assign oRdVld  = rd_vld_q;
  assign oRdDt   = (|rd_vld_q) ? iRdDt : rddt_q;
  assign oLocked = (state_q == S_LOCKED);

endmodule
